// File: rtl/gpu_pkg.sv
// gpu_pkg: arbiter state encoding and default memory widths shared with the LSU.
package gpu_pkg;
  localparam int DEF_ADDR_BITS = 8;
  localparam int DEF_DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first set request at or after ptr.
module rr_picker #(
  parameter int N = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  // Walk from the farthest slot back to ptr so the closest requester is written last.
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: round-robin share of one data-memory port among NUM_LSUS LSUs.
// Define LSU_MEM_ARBITER_STATS_EN to add saturating read/write/wait statistics ports.
module lsu_mem_arbiter
  import gpu_pkg::*;
#(
  parameter int NUM_LSUS  = 4,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_LSUS-1:0]           lsu_read_valid,
  input  logic [NUM_LSUS*ADDR_BITS-1:0] lsu_read_address,
  output logic [NUM_LSUS-1:0]           lsu_read_ready,
  output logic [NUM_LSUS*DATA_BITS-1:0] lsu_read_data,
  input  logic [NUM_LSUS-1:0]           lsu_write_valid,
  input  logic [NUM_LSUS*ADDR_BITS-1:0] lsu_write_address,
  input  logic [NUM_LSUS*DATA_BITS-1:0] lsu_write_data,
  output logic [NUM_LSUS-1:0]           lsu_write_ready,
  output logic                          mem_read_valid,
  output logic [ADDR_BITS-1:0]          mem_read_address,
  input  logic                          mem_read_ready,
  input  logic [DATA_BITS-1:0]          mem_read_data,
  output logic                          mem_write_valid,
  output logic [ADDR_BITS-1:0]          mem_write_address,
  output logic [DATA_BITS-1:0]          mem_write_data,
  input  logic                          mem_write_ready
`ifdef LSU_MEM_ARBITER_STATS_EN
  ,
  output logic [15:0]                   stat_reads,
  output logic [15:0]                   stat_writes,
  output logic [15:0]                   stat_wait_cycles
`endif
);
  localparam int IW = (NUM_LSUS > 1) ? $clog2(NUM_LSUS) : 1;
  arb_state_t state, next_state;
  logic [IW-1:0] rr_ptr, grant, pick;
  logic found;
  logic [NUM_LSUS-1:0] req;
  assign req = lsu_read_valid | lsu_write_valid;
  rr_picker #(.N(NUM_LSUS), .IW(IW)) u_picker (.req(req), .ptr(rr_ptr), .found(found), .idx(pick));
  always_comb begin
    next_state = state;
    case (state)
      IDLE:        next_state = !found ? IDLE : lsu_read_valid[pick] ? READ_WAIT : WRITE_WAIT;
      READ_WAIT:   next_state = mem_read_ready ? READ_RELAY : READ_WAIT;
      WRITE_WAIT:  next_state = mem_write_ready ? WRITE_RELAY : WRITE_WAIT;
      READ_RELAY:  next_state = lsu_read_valid[grant] ? READ_RELAY : IDLE;
      WRITE_RELAY: next_state = lsu_write_valid[grant] ? WRITE_RELAY : IDLE;
      default:     next_state = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= next_state;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      grant <= '0;
      mem_read_valid <= 1'b0;
      mem_read_address <= '0;
      mem_write_valid <= 1'b0;
      mem_write_address <= '0;
      mem_write_data <= '0;
      lsu_read_ready <= '0;
      lsu_write_ready <= '0;
      lsu_read_data <= '0;
    end else begin
      if (state == IDLE && found) begin
        grant <= pick;
        rr_ptr <= (pick == IW'(NUM_LSUS - 1)) ? '0 : pick + 1'b1;
        if (lsu_read_valid[pick]) begin
          mem_read_valid <= 1'b1;
          mem_read_address <= lsu_read_address[pick*ADDR_BITS +: ADDR_BITS];
        end else begin
          mem_write_valid <= 1'b1;
          mem_write_address <= lsu_write_address[pick*ADDR_BITS +: ADDR_BITS];
          mem_write_data <= lsu_write_data[pick*DATA_BITS +: DATA_BITS];
        end
      end
      if (state == READ_WAIT && mem_read_ready) begin
        mem_read_valid <= 1'b0;
        lsu_read_data[grant*DATA_BITS +: DATA_BITS] <= mem_read_data;
        lsu_read_ready[grant] <= 1'b1;
      end
      if (state == WRITE_WAIT && mem_write_ready) begin
        mem_write_valid <= 1'b0;
        lsu_write_ready[grant] <= 1'b1;
      end
      if (state == READ_RELAY && !lsu_read_valid[grant]) lsu_read_ready <= '0;
      if (state == WRITE_RELAY && !lsu_write_valid[grant]) lsu_write_ready <= '0;
    end
  end
`ifdef LSU_MEM_ARBITER_STATS_EN
  logic [NUM_LSUS-1:0] served;
  logic read_grant, write_grant, waiting;
  // The granted LSU counts as served from grant until the arbiter returns to IDLE.
  assign served = (state == IDLE) ? '0 : NUM_LSUS'(1) << grant;
  assign read_grant = state == IDLE && found && lsu_read_valid[pick];
  assign write_grant = state == IDLE && found && !lsu_read_valid[pick];
  assign waiting = |(req & ~served);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_reads <= '0;
      stat_writes <= '0;
      stat_wait_cycles <= '0;
    end else begin
      stat_reads <= stat_reads + 16'(read_grant && stat_reads != 16'hFFFF);
      stat_writes <= stat_writes + 16'(write_grant && stat_writes != 16'hFFFF);
      stat_wait_cycles <= stat_wait_cycles + 16'(waiting && stat_wait_cycles != 16'hFFFF);
    end
  end
`endif
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb_lsu_mem_arbiter: directed checks of arbitration order, relay, reset and hold behaviour.
module tb_lsu_mem_arbiter;
  localparam int N = 4;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] lsu_read_valid, lsu_read_ready, lsu_write_valid, lsu_write_ready;
  logic [N*8-1:0] lsu_read_address, lsu_read_data, lsu_write_address, lsu_write_data;
  logic mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
  logic [7:0] mem_read_address, mem_read_data, mem_write_address, mem_write_data;
`ifdef LSU_MEM_ARBITER_STATS_EN
  logic [15:0] stat_reads, stat_writes, stat_wait_cycles;
`endif
  int compared = 0;
  int mismatched = 0;
  logic [7:0] mem_img [256];
  logic [8:0] log_q [$];
  int rd_seen [N];
  int wr_seen [N];
  int held [N];
  int hold_tgt [N];
  int rel_log [N];
  logic [7:0] rdata_got [N];
  int lat, onehot_err, rd_activity;
  bit resp_en, prev_rv, prev_wv;

  always #5 clock = ~clock;

  lsu_mem_arbiter #(.NUM_LSUS(N), .ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clock(clock), .reset(reset),
    .lsu_read_valid(lsu_read_valid), .lsu_read_address(lsu_read_address),
    .lsu_read_ready(lsu_read_ready), .lsu_read_data(lsu_read_data),
    .lsu_write_valid(lsu_write_valid), .lsu_write_address(lsu_write_address),
    .lsu_write_data(lsu_write_data), .lsu_write_ready(lsu_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
`ifdef LSU_MEM_ARBITER_STATS_EN
    , .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_wait_cycles(stat_wait_cycles)
`endif
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: log new memory grants, model a 2-cycle memory, release LSUs after hold_tgt ready samples.
  task automatic tick();
    @(posedge clock);
    #1;
    if (mem_read_valid && !prev_rv) log_q.push_back({1'b0, mem_read_address});
    if (mem_write_valid && !prev_wv) log_q.push_back({1'b1, mem_write_address});
    prev_rv = mem_read_valid;
    prev_wv = mem_write_valid;
    if ($countones(lsu_read_ready | lsu_write_ready) > 1) onehot_err++;
    if (mem_read_valid || lsu_read_ready != 0) rd_activity++;
    mem_read_ready = 1'b0;
    mem_write_ready = 1'b0;
    if (resp_en && (mem_read_valid || mem_write_valid)) begin
      if (lat == 1) begin
        lat = 0;
        if (mem_read_valid) begin
          mem_read_ready = 1'b1;
          mem_read_data = mem_img[mem_read_address];
        end else begin
          mem_write_ready = 1'b1;
          mem_img[mem_write_address] = mem_write_data;
        end
      end else lat++;
    end
    for (int i = 0; i < N; i++) begin
      if (lsu_read_ready[i]) rd_seen[i]++;
      if (lsu_write_ready[i]) wr_seen[i]++;
      if ((lsu_read_ready[i] && lsu_read_valid[i]) || (lsu_write_ready[i] && lsu_write_valid[i])) begin
        held[i]++;
        if (held[i] >= hold_tgt[i]) begin
          held[i] = 0;
          rel_log[i] = log_q.size();
          if (lsu_read_ready[i]) begin
            lsu_read_valid[i] = 1'b0;
            rdata_got[i] = lsu_read_data[i*8 +: 8];
          end else lsu_write_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic rd(int i, logic [7:0] a);
    lsu_read_address[i*8 +: 8] = a;
    lsu_read_valid[i] = 1'b1;
  endtask

  task automatic wr(int i, logic [7:0] a, logic [7:0] d);
    lsu_write_address[i*8 +: 8] = a;
    lsu_write_data[i*8 +: 8] = d;
    lsu_write_valid[i] = 1'b1;
  endtask

  task automatic drain(string tag, int max_cycles);
    bit done = 0;
    for (int n = 0; n < max_cycles && !done; n++) begin
      tick();
      done = (lsu_read_valid | lsu_write_valid) == 0 && !mem_read_valid && !mem_write_valid &&
             (lsu_read_ready | lsu_write_ready) == 0;
    end
    check({tag, "_drain"}, 32'(done), 1);
  endtask

  task automatic clr();
    log_q.delete();
    rd_activity = 0;
    for (int i = 0; i < N; i++) begin
      rd_seen[i] = 0;
      wr_seen[i] = 0;
      held[i] = 0;
      hold_tgt[i] = 1;
      rel_log[i] = 0;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    lat = 0;
    prev_rv = 1'b0;
    prev_wv = 1'b0;
  endtask

  initial begin
    lsu_read_valid = '0;
    lsu_write_valid = '0;
    lsu_read_address = '0;
    lsu_write_address = '0;
    lsu_write_data = '0;
    mem_read_ready = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data = '0;
    resp_en = 1'b1;
    lat = 0;
    onehot_err = 0;
    prev_rv = 1'b0;
    prev_wv = 1'b0;
    for (int k = 0; k < 256; k++) mem_img[k] = 8'(k) ^ 8'hC3;
    mem_img[8'h0A] = 8'hAB;
    clr();
    @(posedge clock);
    #1;
    check("rst_mem_rv", 32'(mem_read_valid), 0);
    check("rst_mem_wv", 32'(mem_write_valid), 0);
    check("rst_ready", 32'({lsu_read_ready, lsu_write_ready}), 0);
    check("rst_rdata", lsu_read_data, 0);
    check("rst_mem_addr_data", 32'({mem_read_address, mem_write_address, mem_write_data}), 0);
    reset = 1'b1;
    // Single read from LSU0
    rd(0, 8'h0A);
    tick();
    check("t1_mem_rv", 32'(mem_read_valid), 1);
    check("t1_mem_raddr", 32'(mem_read_address), 32'h0A);
    drain("t1", 20);
    check("t1_rdata", 32'(rdata_got[0]), 32'hAB);
    check("t1_ready_samples", rd_seen[0], 1);
    check("t1_grants", log_q.size(), 1);
    // Single write from LSU2
    clr();
    wr(2, 8'h0C, 8'h55);
    tick();
    check("t2_mem_wv", 32'(mem_write_valid), 1);
    check("t2_mem_waddr", 32'(mem_write_address), 32'h0C);
    check("t2_mem_wdata", 32'(mem_write_data), 32'h55);
    drain("t2", 20);
    check("t2_wr_ready", wr_seen[2], 1);
    check("t2_mem_img", 32'(mem_img[8'h0C]), 32'h55);
    check("t2_no_read_activity", rd_activity, 0);
    // Round robin from rr_ptr=0: all four read
    pulse_reset();
    clr();
    for (int i = 0; i < N; i++) rd(i, 8'(8'h10 + i));
    drain("t3a", 60);
    check("t3a_grants", log_q.size(), 4);
    for (int i = 0; i < N; i++) check($sformatf("t3a_grant%0d", i), 32'(log_q[i]), 32'({1'b0, 8'(8'h10 + i)}));
    check("t3a_rdata3", 32'(rdata_got[3]), 32'hD0);
    clr();
    rd(0, 8'h0A);
    drain("t3b", 20);
    clr();
    rd(0, 8'h20);
    rd(3, 8'h23);
    drain("t3c", 40);
    check("t3c_first", 32'(log_q[0]), 32'h023);
    check("t3c_second", 32'(log_q[1]), 32'h020);
    check("t3c_rdata0", 32'(rdata_got[0]), 32'hE3);
    check("t3c_rdata3", 32'(rdata_got[3]), 32'hE0);
    // Read beats write from the same LSU
    clr();
    rd(1, 8'h21);
    wr(1, 8'h31, 8'h77);
    drain("t4", 40);
    check("t4_grants", log_q.size(), 2);
    check("t4_first_read", 32'(log_q[0]), 32'h021);
    check("t4_then_write", 32'(log_q[1]), 32'h131);
    check("t4_rdata1", 32'(rdata_got[1]), 32'hE2);
    check("t4_mem_img", 32'(mem_img[8'h31]), 32'h77);
    // Reset while waiting on memory; rr_ptr was 2 before reset
    clr();
    resp_en = 1'b0;
    rd(1, 8'h40);
    tick();
    check("t5_mem_rv", 32'(mem_read_valid), 1);
    check("t5_mem_raddr", 32'(mem_read_address), 32'h40);
    tick();
    tick();
    rd(3, 8'h43);
    reset = 1'b0;
    #1;
    check("t5_rst_mem_rv", 32'(mem_read_valid), 0);
    check("t5_rst_ready", 32'({lsu_read_ready, lsu_write_ready}), 0);
    check("t5_rst_mem_raddr", 32'(mem_read_address), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    lat = 0;
    prev_rv = 1'b0;
    prev_wv = 1'b0;
    log_q.delete();
    resp_en = 1'b1;
    drain("t5", 40);
    check("t5_grants", log_q.size(), 2);
    check("t5_first", 32'(log_q[0]), 32'h040);
    check("t5_second", 32'(log_q[1]), 32'h043);
    check("t5_rdata1", 32'(rdata_got[1]), 32'h83);
    check("t5_rdata3", 32'(rdata_got[3]), 32'h80);
    // LSU0 holds its relay for 5 ready cycles while LSU2 waits
    clr();
    hold_tgt[0] = 5;
    rd(0, 8'h50);
    rd(2, 8'h51);
    drain("t6", 60);
    check("t6_ready_held", rd_seen[0], 5);
    check("t6_no_grant_during_hold", rel_log[0], 1);
    check("t6_grants", log_q.size(), 2);
    check("t6_second", 32'(log_q[1]), 32'h051);
    check("t6_rdata0", 32'(rdata_got[0]), 32'h93);
    check("t6_rdata2", 32'(rdata_got[2]), 32'h92);
`ifdef LSU_MEM_ARBITER_STATS_EN
    check("t6_stat_reads", 32'(stat_reads), 4);
    check("t6_stat_writes", 32'(stat_writes), 0);
`endif
    check("single_ready_onehot", onehot_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
